layer_output_serializer: RTL and testbench

Collects the per-neuron activation outputs of one hidden layer, which arrive as a parallel bus with per-lane valid strobes, and replays them as a single-word stream. The stream drives the next layer's shared neuron input (`myinput`/`myinputValid`), one element per cycle in neuron order. The block sits between the activation outputs of layer L and the input broadcast of layer L+1. It also adapts the activation ROM width to the datapath width.

---
 rtl/layer_output_serializer_pkg.sv | 29 ++
 rtl/layer_output_serializer_if.sv | 31 +++
 rtl/layer_output_serializer.sv | 116 +++++++++++
 tb/tb_layer_output_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/layer_output_serializer_pkg.sv
// Shared types for the layer-to-layer activation path.
// Reused by the layer-1 input loader.
package layer_output_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SEND
  } ser_state_e;

  localparam int ADAPT_MAXW = 64;

  // Unsigned fractions: zero-extend when narrow, keep MSBs when wide.
  function automatic logic [ADAPT_MAXW-1:0] adapt_width(
    input logic [ADAPT_MAXW-1:0] v,
    input int                    in_w,
    input int                    out_w
  );
    logic [ADAPT_MAXW-1:0] m;
    m = '1;
    if (in_w < ADAPT_MAXW)
      m = (ADAPT_MAXW'(1) << in_w) - ADAPT_MAXW'(1);
    m = v & m;
    if (in_w > out_w)
      m = m >> (in_w - out_w);
    return m;
  endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// Parallel lane bus in, single-word stream out.
// master drives lanes and sinks the stream.
interface layer_output_serializer_if #(
  parameter int numNeurons = 128,
  parameter int inWidth    = 16,
  parameter int outWidth   = 16
);

  logic [numNeurons*inWidth-1:0] lane_data;
  logic [numNeurons-1:0]         lane_valid;
  logic [outWidth-1:0]           out_data;
  logic                          out_valid;
  logic                          out_last;

  modport master (
    output lane_data,
    output lane_valid,
    input  out_data,
    input  out_valid,
    input  out_last
  );

  modport slave (
    input  lane_data,
    input  lane_valid,
    output out_data,
    output out_valid,
    output out_last
  );

endinterface

// File: rtl/layer_output_serializer.sv
// Captures one layer's neuron outputs and replays them
// in neuron order as a one-word-per-cycle stream.
module layer_output_serializer
  import layer_output_serializer_pkg::*;
#(
  parameter int numNeurons = 128,
  parameter int inWidth    = 16,
  parameter int outWidth   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  layer_output_serializer_if.slave   bus,
  output logic                       busy,
  output logic                       overrun
);

  localparam int IW = $clog2(numNeurons + 1);
  localparam int AW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam logic [IW-1:0] LAST = IW'(numNeurons - 1);

  ser_state_e state_q, state_d;

  logic [outWidth-1:0]   buf_q [numNeurons];
  logic [outWidth-1:0]   buf_d [numNeurons];
  logic [numNeurons-1:0] cap_q, cap_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  ovr_q, ovr_d;

  logic [outWidth-1:0]   odata_q, odata_d;
  logic                  ovalid_q, ovalid_d;
  logic                  olast_q, olast_d;

  logic [ADAPT_MAXW-1:0] adapt_v;
  logic [AW-1:0]         rd_idx;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cap_d   = cap_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    adapt_v = '0;
    unique case (state_q)
      IDLE, COLLECT: begin
        for (int i = 0; i < numNeurons; i++) begin
          if (bus.lane_valid[i]) begin
            if (cap_q[i]) begin
              ovr_d = 1'b1;
            end else begin
              adapt_v = adapt_width(
                ADAPT_MAXW'(bus.lane_data[i*inWidth +: inWidth]),
                inWidth, outWidth);
              buf_d[i] = adapt_v[outWidth-1:0];
              cap_d[i] = 1'b1;
            end
          end
        end
        if (&cap_d) begin
          state_d = SEND;
          idx_d   = '0;
        end else if (|cap_d) begin
          state_d = COLLECT;
        end
      end
      SEND: begin
        if (|bus.lane_valid)
          ovr_d = 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          cap_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs lead the state by one edge so element 0 follows capture.
    ovalid_d = (state_d == SEND);
    olast_d  = ovalid_d && (idx_d == LAST);
    rd_idx   = idx_d[AW-1:0];
    odata_d  = ovalid_d ? buf_d[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cap_q    <= '0;
      idx_q    <= '0;
      ovr_q    <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cap_q    <= cap_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign bus.out_data  = odata_q;
  assign bus.out_valid = ovalid_q;
  assign bus.out_last  = olast_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Bench for layer_output_serializer: table, directed
// sequences and randomized traffic against a queue model.
module tb_layer_output_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_output_serializer_if #(.numNeurons(4), .inWidth(16), .outWidth(16)) bus();
  layer_output_serializer_if #(.numNeurons(4), .inWidth(20), .outWidth(16)) w20();
  layer_output_serializer_if #(.numNeurons(4), .inWidth(8),  .outWidth(16)) w8();

  logic busy, overrun, busy20, ovr20, busy8, ovr8;

  layer_output_serializer #(.numNeurons(4), .inWidth(16), .outWidth(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .overrun(overrun));
  layer_output_serializer #(.numNeurons(4), .inWidth(20), .outWidth(16)) dut20 (
    .clk(clk), .rst(rst), .bus(w20), .busy(busy20), .overrun(ovr20));
  layer_output_serializer #(.numNeurons(4), .inWidth(8), .outWidth(16)) dut8 (
    .clk(clk), .rst(rst), .bus(w8), .busy(busy8), .overrun(ovr8));

  int checks = 0;
  int errors = 0;

  logic        s_v, s_l, s_b, s_o;
  logic [15:0] s_d;

  // Reference model: frames collect into a mask, a full frame queues N words.
  logic [15:0] m_buf [4];
  logic [3:0]  m_mask;
  logic        m_ovr;
  logic [15:0] m_q [$];

  typedef struct {
    logic [3:0]  lv;
    logic [63:0] ld;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic        eb;
    logic        eo;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] lv, input logic [63:0] ld);
    logic        ev, el, eb;
    logic [15:0] ed;
    @(negedge clk);
    s_v = bus.out_valid;
    s_d = bus.out_data;
    s_l = bus.out_last;
    s_b = busy;
    s_o = overrun;
    ev = (m_q.size() != 0);
    ed = ev ? m_q[0] : 16'h0;
    el = (m_q.size() == 1);
    eb = ev || (m_mask != 4'h0);
    chk("model out_valid", 32'(s_v), 32'(ev));
    chk("model out_data", 32'(s_d), 32'(ed));
    chk("model out_last", 32'(s_l), 32'(el));
    chk("model busy", 32'(s_b), 32'(eb));
    chk("model overrun", 32'(s_o), 32'(m_ovr));
    if (ev) void'(m_q.pop_front());
    rst = r;
    bus.lane_valid = lv;
    bus.lane_data = ld;
    if (r) begin
      m_q.delete();
      m_mask = 4'h0;
      m_ovr = 1'b0;
    end else if (ev) begin
      if (lv != 4'h0) m_ovr = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (lv[i]) begin
          if (m_mask[i]) m_ovr = 1'b1;
          else begin
            m_buf[i] = ld[i*16 +: 16];
            m_mask[i] = 1'b1;
          end
        end
      end
      if (m_mask == 4'hF) begin
        for (int i = 0; i < 4; i++) m_q.push_back(m_buf[i]);
        m_mask = 4'h0;
      end
    end
  endtask

  task automatic stream4(input string nm, input logic [63:0] exp);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 4'h0, 64'h0);
      chk({nm, " valid"}, 32'(s_v), 32'd1);
      chk({nm, " data"}, 32'(s_d), 32'(exp[k*16 +: 16]));
      chk({nm, " last"}, 32'(s_l), 32'(k == 3));
    end
  endtask

  logic [63:0] ld_a, ld_b;
  logic [79:0] d20;
  logic [31:0] d8;
  logic [63:0] e20, e8;
  logic [3:0]  rlv;

  initial begin
    tbl[0] = '{4'hF, 64'h4444_3333_2222_1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'h0, 64'h0,                   1'b1, 16'h1111, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'h0, 64'h0,                   1'b1, 16'h2222, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'h0, 64'h0,                   1'b1, 16'h3333, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'h0, 64'h0,                   1'b1, 16'h4444, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{4'h0, 64'h0,                   1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    m_mask = 4'h0;
    m_ovr = 1'b0;
    bus.lane_valid = '0;
    bus.lane_data = '0;
    w20.lane_valid = '0;
    w20.lane_data = '0;
    w8.lane_valid = '0;
    w8.lane_data = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    cyc(1'b0, 4'h0, 64'h0);
    chk("reset out_valid", 32'(s_v), 32'd0);
    chk("reset out_data", 32'(s_d), 32'd0);
    chk("reset busy", 32'(s_b), 32'd0);
    chk("reset overrun", 32'(s_o), 32'd0);

    // All lanes together
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, tbl[k].lv, tbl[k].ld);
      chk("tbl valid", 32'(s_v), 32'(tbl[k].ev));
      chk("tbl data", 32'(s_d), 32'(tbl[k].ed));
      chk("tbl last", 32'(s_l), 32'(tbl[k].el));
      chk("tbl busy", 32'(s_b), 32'(tbl[k].eb));
      chk("tbl overrun", 32'(s_o), 32'(tbl[k].eo));
    end

    // Out-of-order arrival
    ld_a = 64'h3D3D_2C2C_1B1B_0A0A;
    cyc(1'b0, 4'b0100, ld_a);
    cyc(1'b0, 4'b0000, 64'h0);
    chk("ooo busy collecting", 32'(s_b), 32'd1);
    chk("ooo no early valid", 32'(s_v), 32'd0);
    cyc(1'b0, 4'b1001, ld_a);
    cyc(1'b0, 4'b0000, 64'h0);
    cyc(1'b0, 4'b0010, ld_a);
    stream4("ooo", ld_a);
    cyc(1'b0, 4'h0, 64'h0);
    chk("ooo overrun", 32'(s_o), 32'd0);
    chk("ooo busy done", 32'(s_b), 32'd0);

    // Duplicate lane
    cyc(1'b0, 4'b0010, 64'h0000_0000_AAAA_0000);
    cyc(1'b0, 4'b0010, 64'h0000_0000_BBBB_0000);
    cyc(1'b0, 4'b1101, 64'h4444_3333_0000_1111);
    stream4("dup", 64'h4444_3333_AAAA_1111);
    chk("dup overrun", 32'(s_o), 32'd1);
    cyc(1'b0, 4'h0, 64'h0);

    // Capture during SEND, then a full set right after out_last
    cyc(1'b1, 4'h0, 64'h0);
    cyc(1'b0, 4'h0, 64'h0);
    chk("rst clears overrun", 32'(s_o), 32'd0);
    ld_a = 64'hA004_A003_A002_A001;
    ld_b = 64'hB004_B003_B002_B001;
    cyc(1'b0, 4'hF, ld_a);
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0, 64'h0);
    cyc(1'b0, 4'hF, 64'hDEAD_DEAD_DEAD_DEAD);
    chk("send last flag", 32'(s_l), 32'd1);
    chk("send last data", 32'(s_d), 32'h0000_A004);
    cyc(1'b0, 4'hF, ld_b);
    chk("send overrun", 32'(s_o), 32'd1);
    chk("send gap valid", 32'(s_v), 32'd0);
    stream4("post", ld_b);
    cyc(1'b0, 4'h0, 64'h0);

    // Reset mid-SEND
    cyc(1'b0, 4'hF, 64'hC004_C003_C002_C001);
    cyc(1'b0, 4'h0, 64'h0);
    cyc(1'b0, 4'h0, 64'h0);
    cyc(1'b1, 4'h0, 64'h0);
    chk("midrst el2", 32'(s_d), 32'h0000_C003);
    cyc(1'b0, 4'h0, 64'h0);
    chk("midrst valid", 32'(s_v), 32'd0);
    chk("midrst busy", 32'(s_b), 32'd0);
    chk("midrst overrun", 32'(s_o), 32'd0);
    chk("midrst data", 32'(s_d), 32'd0);
    cyc(1'b0, 4'hF, 64'hD004_D003_D002_D001);
    stream4("fresh", 64'hD004_D003_D002_D001);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) rlv = 4'hF;
      else rlv = 4'($urandom) & 4'($urandom);
      cyc(($urandom_range(0, 149) == 0), rlv, {$urandom, $urandom});
    end

    // Width adaptation
    cyc(1'b1, 4'h0, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    d20 = {20'h0000F, 20'hFFFFF, 20'h12345, 20'hABCDE};
    e20 = 64'h0000_FFFF_1234_ABCD;
    d8  = {8'h80, 8'hFF, 8'h01, 8'hF0};
    e8  = 64'h0080_00FF_0001_00F0;
    w20.lane_valid = 4'hF;
    w20.lane_data = d20;
    w8.lane_valid = 4'hF;
    w8.lane_data = d8;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w20.lane_valid = 4'h0;
      w8.lane_valid = 4'h0;
      chk("w20 valid", 32'(w20.out_valid), 32'd1);
      chk("w20 data", 32'(w20.out_data), 32'(e20[k*16 +: 16]));
      chk("w8 data", 32'(w8.out_data), 32'(e8[k*16 +: 16]));
      chk("w8 busy", 32'(busy8), 32'd1);
    end
    @(negedge clk);
    chk("w20 idle", 32'(busy20), 32'd0);
    chk("w20 overrun", 32'(ovr20), 32'd0);
    chk("w8 overrun", 32'(ovr8), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
